// File: rtl/back_ground_layer_draw.sv
// Background layer: sky/ground split, bracket border, 256-colour palette strip with scroll/blink animation.
// Latency: 2 clk from pixelX/pixelY to BG_RGB/boardersDrawReq, outputs always aligned.
// Backpressure: none; a new pixel is accepted every clock, frame state updates only on startOfFrame.
//
// Ports:
//   clk, resetN            pixel clock, asynchronous active-low reset
//   startOfFrame           one-cycle pulse at the start of each frame
//   pixelX, pixelY         current pixel coordinates (11 bit)
//   scrollEn, blinkEn      animation enables, sampled on startOfFrame only
//   BG_RGB                 background colour {B[1:0],R[2:0],G[2:0]}
//   boardersDrawReq        high for visible border pixels and strip pixels
//
// Configuration macro: BG_BLINK_EN (defined -> border blinking implemented; undefined -> blinkEn ignored).

module back_ground_layer_draw #(
  parameter int         X_FRAME_SIZE   = 635,
  parameter int         Y_FRAME_SIZE   = 475,
  parameter int         BRACKET_OFFSET = 32,
  parameter int         BORDER_THICK   = 8,
  parameter int         GROUND_Y       = 120,
  parameter logic [7:0] SKY_RGB        = 8'h3F,
  parameter logic [7:0] GROUND_RGB     = 8'h2C,
  parameter logic [7:0] BORDER_RGB     = 8'h07,
  parameter int         STRIP_LEFT_X   = 30,
  parameter int         STRIP_TOP_Y    = 4,
  parameter int         STRIP_H        = 15,
  parameter int         CELL_W_LOG2    = 1,
  parameter int         SCROLL_STEP    = 1,
  parameter int         BLINK_FRAMES   = 30
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        scrollEn,
  input  logic        blinkEn,
  output logic [7:0]  BG_RGB,
  output logic        boardersDrawReq
);

  // Inclusive border band limits.
  localparam int BL_LO = BRACKET_OFFSET - BORDER_THICK;
  localparam int BL_HI = BRACKET_OFFSET;
  localparam int BR_LO = X_FRAME_SIZE - BRACKET_OFFSET;
  localparam int BR_HI = X_FRAME_SIZE - BRACKET_OFFSET + BORDER_THICK;
  localparam int BT_LO = BRACKET_OFFSET - BORDER_THICK;
  localparam int BT_HI = BRACKET_OFFSET;
  localparam int BB_LO = Y_FRAME_SIZE - BRACKET_OFFSET;
  localparam int BB_HI = Y_FRAME_SIZE - BRACKET_OFFSET + BORDER_THICK;

  // Strip occupies STRIP_LEFT_X+1 .. STRIP_X_HI and STRIP_TOP_Y+1 .. STRIP_Y_HI.
  localparam int STRIP_X_HI = STRIP_LEFT_X + (256 << CELL_W_LOG2);
  localparam int STRIP_Y_HI = STRIP_TOP_Y + STRIP_H;

  int px;
  int py;
  assign px = int'(pixelX);
  assign py = int'(pixelY);

  // ---------------- frame control: scroll ----------------
  logic       scroll_mode_d, scroll_mode_q;
  logic [7:0] scroll_ofs_d,  scroll_ofs_q;

  always_comb begin
    scroll_mode_d = startOfFrame ? scrollEn : scroll_mode_q;
    scroll_ofs_d  = scroll_ofs_q;
    if (startOfFrame && scroll_mode_d) begin
      scroll_ofs_d = scroll_ofs_q + 8'(SCROLL_STEP);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scroll_mode_q <= 1'b0;
      scroll_ofs_q  <= 8'h00;
    end else begin
      scroll_mode_q <= scroll_mode_d;
      scroll_ofs_q  <= scroll_ofs_d;
    end
  end

  // ---------------- frame control: blink ----------------
  logic blink_phase;

`ifdef BG_BLINK_EN
  localparam int              BCW        = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BCW-1:0]  BLINK_LAST = BCW'(BLINK_FRAMES - 1);

  logic           blink_mode_d,  blink_mode_q;
  logic           blink_phase_d, blink_phase_q;
  logic [BCW-1:0] blink_cnt_d,   blink_cnt_q;

  always_comb begin
    blink_mode_d  = startOfFrame ? blinkEn : blink_mode_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (startOfFrame) begin
      if (blink_mode_d) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d   = blink_cnt_q + BCW'(1);
        end
      end else begin
        // Leaving blink mode forces the border solid immediately.
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_mode_q  <= 1'b0;
      blink_phase_q <= 1'b0;
      blink_cnt_q   <= '0;
    end else begin
      blink_mode_q  <= blink_mode_d;
      blink_phase_q <= blink_phase_d;
      blink_cnt_q   <= blink_cnt_d;
    end
  end

  assign blink_phase = blink_phase_q;
`else
  logic unused_blink_en;
  assign unused_blink_en = blinkEn;
  assign blink_phase     = 1'b0;
`endif

  // ---------------- stage 1: region decode ----------------
  logic       is_strip_d,  is_strip_q;
  logic       is_border_d, is_border_q;
  logic       is_ground_d, is_ground_q;
  logic [7:0] cell_idx_d,  cell_idx_q;
  logic       in_border;

  always_comb begin
    in_border = ((px >= BL_LO) && (px <= BL_HI)) || ((px >= BR_LO) && (px <= BR_HI)) ||
                ((py >= BT_LO) && (py <= BT_HI)) || ((py >= BB_LO) && (py <= BB_HI));
    is_strip_d  = (px > STRIP_LEFT_X) && (px <= STRIP_X_HI) &&
                  (py > STRIP_TOP_Y)  && (py <= STRIP_Y_HI);
    // Blanked border pixels fall through to the sky/ground colour underneath.
    is_border_d = in_border && !blink_phase;
    is_ground_d = (py >= GROUND_Y);
    // Uses the pre-update offset when startOfFrame coincides with this pixel.
    cell_idx_d  = 8'((px - STRIP_LEFT_X - 1) >> CELL_W_LOG2) + scroll_ofs_q;
  end

  // ---------------- stage 2: colour select ----------------
  logic [7:0] bg_rgb_d, bg_rgb_q;
  logic       req_d,    req_q;

  always_comb begin
    if (is_strip_q) begin
      bg_rgb_d = cell_idx_q;
    end else if (is_border_q) begin
      bg_rgb_d = BORDER_RGB;
    end else if (is_ground_q) begin
      bg_rgb_d = GROUND_RGB;
    end else begin
      bg_rgb_d = SKY_RGB;
    end
    req_d = is_strip_q || is_border_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      is_strip_q  <= 1'b0;
      is_border_q <= 1'b0;
      is_ground_q <= 1'b0;
      cell_idx_q  <= 8'h00;
      bg_rgb_q    <= 8'h00;
      req_q       <= 1'b0;
    end else begin
      is_strip_q  <= is_strip_d;
      is_border_q <= is_border_d;
      is_ground_q <= is_ground_d;
      cell_idx_q  <= cell_idx_d;
      bg_rgb_q    <= bg_rgb_d;
      req_q       <= req_d;
    end
  end

  assign BG_RGB          = bg_rgb_q;
  assign boardersDrawReq = req_q;

endmodule

// File: tb/tb_back_ground_layer_draw.sv
// Directed bench for back_ground_layer_draw: reset, regions, strip, scrolling, blink, mid-frame reset.
// Latency: pixels are checked 2 clk after being driven, sampled 1 time unit after the clock edge.
// Backpressure: not applicable; stimulus is driven every cycle.

module tb_back_ground_layer_draw;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        scrollEn;
  logic        blinkEn;
  logic [7:0]  BG_RGB;
  logic        boardersDrawReq;

  int n_cmp = 0;
  int n_bad = 0;

  back_ground_layer_draw #(.BLINK_FRAMES(2)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .scrollEn       (scrollEn),
    .blinkEn        (blinkEn),
    .BG_RGB         (BG_RGB),
    .boardersDrawReq(boardersDrawReq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {x, y, expected rgb, expected req}
  localparam int REG_T [15][4] = '{
    '{300,  50, 'h3F, 0}, '{ 28, 200, 'h07, 1}, '{ 23, 200, 'h2C, 0},
    '{ 24, 200, 'h07, 1}, '{ 32, 200, 'h07, 1}, '{ 33, 200, 'h2C, 0},
    '{611, 300, 'h07, 1}, '{612, 300, 'h2C, 0}, '{603, 300, 'h07, 1},
    '{300, 451, 'h07, 1}, '{300, 452, 'h2C, 0}, '{300, 443, 'h07, 1},
    '{300,  24, 'h07, 1}, '{300, 119, 'h3F, 0}, '{300, 120, 'h2C, 0}
  };

  localparam int STRIP_T [10][4] = '{
    '{ 31, 10, 'h00, 1}, '{ 32, 10, 'h00, 1}, '{ 33, 10, 'h01, 1},
    '{542, 10, 'hFF, 1}, '{543, 10, 'h3F, 0}, '{ 30, 10, 'h07, 1},
    '{100,  5, 'h22, 1}, '{100, 19, 'h22, 1}, '{100, 20, 'h3F, 0},
    '{100,  4, 'h3F, 0}
  };

  task automatic drive_pix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    startOfFrame = 1'b1;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    pixelX = 11'd300;
    pixelY = 11'd300;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (BG_RGB !== 8'h00) begin
      n_bad++; $display("FAIL reset_rgb got %h want %h", BG_RGB, 8'h00);
    end
    n_cmp++;
    if (boardersDrawReq !== 1'b0) begin
      n_bad++; $display("FAIL reset_req got %b want %b", boardersDrawReq, 1'b0);
    end
    resetN = 1'b1;
    drive_pix(300, 300);
    n_cmp++;
    if (BG_RGB !== 8'h2C) begin
      n_bad++; $display("FAIL release_rgb got %h want %h", BG_RGB, 8'h2C);
    end
  endtask

  task automatic test_latency();
    drive_pix(300, 50);
    pixelX = 11'd300;
    pixelY = 11'd300;
    @(posedge clk);
    #1;
    n_cmp++;
    if (BG_RGB !== 8'h3F) begin
      n_bad++; $display("FAIL latency_1clk got %h want %h", BG_RGB, 8'h3F);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (BG_RGB !== 8'h2C) begin
      n_bad++; $display("FAIL latency_2clk got %h want %h", BG_RGB, 8'h2C);
    end
  endtask

  task automatic test_regions();
    for (int i = 0; i < 15; i++) begin
      drive_pix(REG_T[i][0], REG_T[i][1]);
      n_cmp++;
      if (BG_RGB !== 8'(REG_T[i][2])) begin
        n_bad++; $display("FAIL region[%0d] rgb got %h want %h", i, BG_RGB, 8'(REG_T[i][2]));
      end
      n_cmp++;
      if (boardersDrawReq !== 1'(REG_T[i][3])) begin
        n_bad++; $display("FAIL region[%0d] req got %b want %b", i, boardersDrawReq, 1'(REG_T[i][3]));
      end
    end
  endtask

  task automatic test_strip();
    for (int i = 0; i < 10; i++) begin
      drive_pix(STRIP_T[i][0], STRIP_T[i][1]);
      n_cmp++;
      if (BG_RGB !== 8'(STRIP_T[i][2])) begin
        n_bad++; $display("FAIL strip[%0d] rgb got %h want %h", i, BG_RGB, 8'(STRIP_T[i][2]));
      end
      n_cmp++;
      if (boardersDrawReq !== 1'(STRIP_T[i][3])) begin
        n_bad++; $display("FAIL strip[%0d] req got %b want %b", i, boardersDrawReq, 1'(STRIP_T[i][3]));
      end
    end
  endtask

  task automatic test_scroll();
    scrollEn = 1'b1;
    repeat (3) frame_pulse();
    drive_pix(31, 10);
    n_cmp++;
    if (BG_RGB !== 8'h03) begin
      n_bad++; $display("FAIL scroll3_x31 got %h want %h", BG_RGB, 8'h03);
    end
    drive_pix(33, 10);
    n_cmp++;
    if (BG_RGB !== 8'h04) begin
      n_bad++; $display("FAIL scroll3_x33 got %h want %h", BG_RGB, 8'h04);
    end
    repeat (253) frame_pulse();
    drive_pix(31, 10);
    n_cmp++;
    if (BG_RGB !== 8'h00) begin
      n_bad++; $display("FAIL scroll_wrap got %h want %h", BG_RGB, 8'h00);
    end
    // Pulse coincident with a strip pixel: that pixel sees the old offset.
    pixelX = 11'd31;
    pixelY = 11'd10;
    startOfFrame = 1'b1;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (BG_RGB !== 8'h00) begin
      n_bad++; $display("FAIL sof_same_pixel got %h want %h", BG_RGB, 8'h00);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (BG_RGB !== 8'h01) begin
      n_bad++; $display("FAIL sof_next_pixel got %h want %h", BG_RGB, 8'h01);
    end
    scrollEn = 1'b0;
    repeat (2) frame_pulse();
    drive_pix(31, 10);
    n_cmp++;
    if (BG_RGB !== 8'h01) begin
      n_bad++; $display("FAIL scroll_hold got %h want %h", BG_RGB, 8'h01);
    end
  endtask

  task automatic test_midframe_reset();
    scrollEn = 1'b1;
    repeat (3) frame_pulse();
    scrollEn = 1'b0;
    drive_pix(28, 200);
    resetN = 1'b0;
    #1;
    n_cmp++;
    if (BG_RGB !== 8'h00 || boardersDrawReq !== 1'b0) begin
      n_bad++; $display("FAIL midframe_reset got %h/%b want %h/%b", BG_RGB, boardersDrawReq, 8'h00, 1'b0);
    end
    @(posedge clk);
    #1;
    resetN = 1'b1;
    drive_pix(31, 10);
    n_cmp++;
    if (BG_RGB !== 8'h00) begin
      n_bad++; $display("FAIL reset_scroll_restart got %h want %h", BG_RGB, 8'h00);
    end
  endtask

`ifdef BG_BLINK_EN
  task automatic test_blink();
    // Expected border visibility after k frame pulses with BLINK_FRAMES=2.
    logic solid_exp [7];
    solid_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    blinkEn = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive_pix(28, 200);
      n_cmp++;
      if (BG_RGB !== (solid_exp[k] ? 8'h07 : 8'h2C)) begin
        n_bad++; $display("FAIL blink_frame%0d rgb got %h want %h", k, BG_RGB, solid_exp[k] ? 8'h07 : 8'h2C);
      end
      n_cmp++;
      if (boardersDrawReq !== solid_exp[k]) begin
        n_bad++; $display("FAIL blink_frame%0d req got %b want %b", k, boardersDrawReq, solid_exp[k]);
      end
      if (!solid_exp[k]) begin
        drive_pix(33, 10);
        n_cmp++;
        if (BG_RGB !== 8'h01 || boardersDrawReq !== 1'b1) begin
          n_bad++; $display("FAIL blink_strip%0d got %h/%b want %h/%b", k, BG_RGB, boardersDrawReq, 8'h01, 1'b1);
        end
      end
      if (k < 6) frame_pulse();
    end
    blinkEn = 1'b0;
    frame_pulse();
    drive_pix(28, 200);
    n_cmp++;
    if (BG_RGB !== 8'h07 || boardersDrawReq !== 1'b1) begin
      n_bad++; $display("FAIL blink_off got %h/%b want %h/%b", BG_RGB, boardersDrawReq, 8'h07, 1'b1);
    end
  endtask
`else
  task automatic test_blink();
    do_reset();
    blinkEn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      frame_pulse();
      drive_pix(28, 200);
      n_cmp++;
      if (BG_RGB !== 8'h07) begin
        n_bad++; $display("FAIL noblink_frame%0d rgb got %h want %h", k, BG_RGB, 8'h07);
      end
      n_cmp++;
      if (boardersDrawReq !== 1'b1) begin
        n_bad++; $display("FAIL noblink_frame%0d req got %b want %b", k, boardersDrawReq, 1'b1);
      end
    end
    blinkEn = 1'b0;
  endtask
`endif

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    scrollEn     = 1'b0;
    blinkEn      = 1'b0;
    pixelX       = 11'd0;
    pixelY       = 11'd0;
    #1;
    test_reset();
    test_latency();
    test_regions();
    test_strip();
    test_scroll();
    test_midframe_reset();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
